// File: rtl/mdu_ctrl.sv
// Iterative MIPS multiply/divide unit with HI/LO: shift-add multiply, restoring divide, one bit per cycle.
// Latency WIDTH+1 cycles in the background; any MDU instruction arriving while busy is stalled (held) until idle.
module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hilo_out
);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opb;
    logic [WIDTH-1:0]     hi, lo;
    logic                 op_div, neg_res, neg_rem, div_zero;

    logic                 is_arith, is_mdu, is_div_op, is_signed_op, accept;
    logic [WIDTH-1:0]     mag_a, mag_b;

    assign is_arith     = (func == F_MULT) || (func == F_MULTU) || (func == F_DIV) || (func == F_DIVU);
    assign is_mdu       = is_arith || (func == F_MFHI) || (func == F_MTHI) ||
                          (func == F_MFLO) || (func == F_MTLO);
    assign is_div_op    = (func == F_DIV) || (func == F_DIVU);
    assign is_signed_op = (func == F_MULT) || (func == F_DIV);

    assign busy   = (state != IDLE);
    assign stall  = start && is_mdu && busy && !flush;
    assign accept = start && is_mdu && !flush && !stall;
    assign done   = (state == FIX) && !flush;

    assign mag_a = (is_signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
    assign mag_b = (is_signed_op && src_b[WIDTH-1]) ? -src_b : src_b;

    always_comb begin
        hilo_out = '0;
        if (func == F_MFHI)
            hilo_out = hi;
        else if (func == F_MFLO)
            hilo_out = lo;
    end

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_nxt;
    // Divide step: acc = {partial remainder, dividend bits shifting into quotient}.
    logic [WIDTH:0]       div_sh;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_nxt;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        mul_nxt  = {mul_sum, acc[WIDTH-1:1]};
        div_sh   = acc[2*WIDTH-1:WIDTH-1];
        div_ge   = (div_sh >= {1'b0, opb});
        div_diff = div_sh[WIDTH-1:0] - opb;
        div_nxt  = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    end

    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo, rem, res_hi, res_lo;

    always_comb begin
        prod   = neg_res ? -acc : acc;
        quo    = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (op_div) begin
            // With a zero divisor the remainder path reproduces the dividend, so only LO needs forcing.
            res_hi = neg_rem ? -rem : rem;
            res_lo = div_zero ? '1 : (neg_res ? -quo : quo);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && is_arith) state_nxt = RUN;
            RUN: begin
                if (flush)
                    state_nxt = IDLE;
                else if (cnt == CNT_LAST)
                    state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            acc      <= '0;
            opb      <= '0;
            cnt      <= '0;
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept) begin
            if (func == F_MTHI)
                hi <= src_a;
            if (func == F_MTLO)
                lo <= src_a;
            if (is_arith) begin
                op_div   <= is_div_op;
                neg_res  <= is_signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                neg_rem  <= is_signed_op && src_a[WIDTH-1];
                div_zero <= is_div_op && (src_b == '0);
                acc      <= {{WIDTH{1'b0}}, (is_div_op ? mag_a : mag_b)};
                opb      <= is_div_op ? mag_b : mag_a;
                cnt      <= '0;
            end
        end else if (state == RUN && !flush) begin
            acc <= op_div ? div_nxt : mul_nxt;
            cnt <= cnt + 1'b1;
        end else if (state == FIX && !flush) begin
            hi <= res_hi;
            lo <= res_lo;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed cases plus randomized ops against an arithmetic reference model;
// read data is checked through an expected-value queue popped by an independent monitor.
module tb_mdu_ctrl;

    localparam int W = 32;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [5:0]   func;
    logic [W-1:0] src_a, src_b;
    logic         flush;
    logic         stall, busy, done;
    logic [W-1:0] hilo_out;

    int           total = 0;
    int           bad   = 0;
    logic [31:0]  hi_m, lo_m;
    logic [31:0]  exp_q[$];
    logic [31:0]  mon_exp;
    logic [5:0]   ar_ops[4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
    logic [5:0]   non_mdu[6] = '{6'h20, 6'h21, 6'h1c, 6'h14, 6'h00, 6'h2a};

    mdu_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .func     (func),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .hilo_out (hilo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic, returns {HI, LO}.
    function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, m;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (f == F_MULT)
            return 64'(sa * sb);
        if (f == F_MULTU)
            return ua * ub;
        if (b == 32'd0)
            return {a, 32'hFFFF_FFFF};
        if (f == F_DIV) begin
            q = sa / sb;
            m = sa % sb;
            return {m[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 20));
            5:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && start && !flush && !stall && (func == F_MFHI || func == F_MFLO)) begin
            if (exp_q.size() == 0) begin
                check("read_unexpected", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check((func == F_MFHI) ? "read_hi" : "read_lo", 64'(hilo_out), 64'(mon_exp));
            end
        end
    end

    // Holds the instruction until it is no longer stalled; returns with the accept edge just past.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int waits);
        start = 1'b1;
        func  = f;
        src_a = a;
        src_b = b;
        waits = 0;
        forever begin
            @(negedge clk);
            if (!stall)
                break;
            waits++;
            if (waits > 100) begin
                check("issue_timeout", 64'(waits), 64'd0);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        func  = 6'h20;
        src_a = $urandom;
        src_b = $urandom;
    endtask

    task automatic rd(input bit sel_hi, output int waits);
        exp_q.push_back(sel_hi ? hi_m : lo_m);
        issue(sel_hi ? F_MFHI : F_MFLO, $urandom, $urandom, waits);
    endtask

    // Watches cycles 1..40 after an accept; optionally flushes in cycle fc.
    task automatic observe(input int fc, output int bcnt, output int dcnt, output int dcyc);
        bcnt = 0;
        dcnt = 0;
        dcyc = 0;
        for (int c = 1; c <= 40; c++) begin
            flush = (c == fc);
            @(negedge clk);
            if (busy)
                bcnt++;
            if (done) begin
                dcnt++;
                dcyc = c;
            end
            @(posedge clk); #1;
        end
        flush = 1'b0;
    endtask

    task automatic directed(input string name, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int w, bc, dc, dy;
        issue(f, a, b, w);
        observe(0, bc, dc, dy);
        check({name, "_busy_cycles"}, 64'(bc), 64'd33);
        check({name, "_done_count"}, 64'(dc), 64'd1);
        check({name, "_done_cycle"}, 64'(dy), 64'd33);
        hi_m = eh;
        lo_m = el;
        rd(1'b1, w);
        rd(1'b0, w);
        check({name, "_read_wait"}, 64'(w), 64'd0);
    endtask

    initial begin
        int          w, bc, dc, dy, sel;
        logic [5:0]  f;
        logic [31:0] a, b;
        logic [63:0] r;

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        func  = 6'h20;
        src_a = '0;
        src_b = '0;
        hi_m  = '0;
        lo_m  = '0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        rd(1'b1, w);
        check("reset_mfhi_wait", 64'(w), 64'd0);
        rd(1'b0, w);

        // multu with a dependent mflo issued in cycle 5
        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
        hi_m = 32'hFFFF_FFFE;
        lo_m = 32'h0000_0001;
        repeat (4) begin @(posedge clk); #1; end
        rd(1'b0, w);
        check("multu_mflo_stall_cycles", 64'(w), 64'd29);
        rd(1'b1, w);

        directed("multu", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        directed("mult_neg", F_MULT, -32'd7, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        directed("div_neg", F_DIV, -32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        directed("divu", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        directed("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        directed("div_zero", F_DIV, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);

        // mthi visible to an mfhi in the very next cycle
        issue(F_MTHI, 32'hA5A5_A5A5, 32'd0, w);
        hi_m = 32'hA5A5_A5A5;
        rd(1'b1, w);
        check("mthi_then_mfhi_wait", 64'(w), 64'd0);

        // flushed multiply leaves HI/LO alone and never raises done
        issue(F_MULT, 32'd2, 32'd3, w);
        observe(4, bc, dc, dy);
        check("flush_busy_cycles", 64'(bc), 64'd4);
        check("flush_done_count", 64'(dc), 64'd0);
        rd(1'b1, w);
        rd(1'b0, w);

        // flush wins over a simultaneous mtlo and a simultaneous mult
        start = 1'b1;
        func  = F_MTLO;
        src_a = 32'h5A5A_0001;
        flush = 1'b1;
        @(negedge clk);
        check("flush_start_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        func = F_MULT;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush_start_mult_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rd(1'b0, w);

        // asynchronous reset in RUN cycle 10
        issue(F_MTHI, 32'h1111_1111, 32'd0, w);
        issue(F_MULT, 32'd5, 32'd9, w);
        repeat (9) begin @(posedge clk); #1; end
        func = F_MFHI;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_busy", 64'(busy), 64'd0);
        check("midrun_reset_done", 64'(done), 64'd0);
        check("midrun_reset_hi", 64'(hilo_out), 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        hi_m = '0;
        lo_m = '0;
        rd(1'b1, w);
        rd(1'b0, w);

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                f = ar_ops[$urandom_range(0, 3)];
                a = rnd_val();
                b = rnd_val();
                issue(f, a, b, w);
                r = ref_op(f, a, b);
                hi_m = r[63:32];
                lo_m = r[31:0];
                start = 1'b1;
                func  = non_mdu[$urandom_range(0, 5)];
                @(negedge clk);
                check("nonmdu_stall", 64'(stall), 64'd0);
                check("nonmdu_busy", 64'(busy), 64'd1);
                check("nonmdu_hilo", 64'(hilo_out), 64'd0);
                @(posedge clk); #1;
                start = 1'b0;
                repeat ($urandom_range(0, 34)) begin @(posedge clk); #1; end
                rd($urandom_range(0, 1) == 1, w);
                rd($urandom_range(0, 1) == 1, w);
            end else if (sel < 6) begin
                a = $urandom;
                issue((sel == 4) ? F_MTHI : F_MTLO, a, $urandom, w);
                if (sel == 4)
                    hi_m = a;
                else
                    lo_m = a;
            end else begin
                rd($urandom_range(0, 1) == 1, w);
            end
        end

        repeat (2) begin @(posedge clk); #1; end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
